rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between N_REQ requesters.
- Built around a small grant FSM: IDLE, GRANT, RELEASE.
- Rotating priority pointer cycles 0 -> 1 -> ... -> N_REQ-1 -> 0.
- Sits between requesting sub-blocks and the shared resource; drives a registered one-hot grant plus grant index.

Parameters:
- N_REQ, 3, number of requesters (>=2).
- HOLD_MAX, 8, max consecutive GRANT cycles per owner before forced release (timeout feature only; >=1).
- ID_W, $clog2(N_REQ), width of o_gnt_id.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  N_REQ  request per requester; held high while the resource is wanted.
- o_gnt  output  N_REQ  registered one-hot grant; all-zero when nobody owns.
- o_gnt_id  output  ID_W  index of current owner; 0 when idle.
- o_busy  output  1  high while in GRANT.
- o_timeout  output  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, pointer=0, hold count=0.
  - o_gnt=0, o_gnt_id=0, o_busy=0, o_timeout=0.
  - Reset asserted mid-grant drops the grant immediately; no RELEASE cycle.
- Selection:
  - Winner = first requester with i_req high, searching from pointer upward with wrap at N_REQ-1 -> 0.
  - Purely combinational from i_req and pointer.
- IDLE:
  - Evaluated every cycle.
  - Any i_req high -> GRANT; o_gnt/o_gnt_id/o_busy registered on the same edge. Latency: request seen at edge t, grant visible after edge t.
  - No request -> stay IDLE.
  - A request that drops before being sampled is ignored.
- GRANT:
  - Owner held; other requests ignored.
  - i_req[owner]=0 -> RELEASE.
  - Hold count increments each GRANT cycle.
- RELEASE:
  - Exactly one cycle with o_gnt=0, o_busy=0 (bus turnaround).
  - pointer <= (owner+1) mod N_REQ; hold count cleared; next state IDLE.
  - Requests arriving here are evaluated in IDLE the following cycle. Minimum re-grant gap is 2 cycles after the owner drops.
- Fairness:
  - Continuous contention serves requesters in index order starting after the last owner.
  - A single persistent requester is re-granted after each RELEASE/IDLE pair.
- State encoding: 2-bit. The unused code 2'b11 goes to IDLE with o_gnt cleared.
- Widths: pointer is ID_W bits with explicit wrap compare (N_REQ need not be a power of 2). Hold counter is $clog2(HOLD_MAX+1) bits and saturates.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold count reaches HOLD_MAX with i_req[owner] still high, go to RELEASE and pulse o_timeout for that one RELEASE cycle.
  - Pointer advances past the owner as in a normal release.
  - If the owner drops i_req on the same cycle the limit is reached, it is a normal release and o_timeout stays 0.
- Undefined:
  - No hold counter; grant is held until the owner drops its request.
  - o_timeout is constant 0.

Decomposition:
- Shared package/header arb_pkg:
  - state constants ARB_IDLE=2'b00, ARB_GRANT=2'b01, ARB_RELEASE=2'b10.
  - default N_REQ and HOLD_MAX values.
- One sub-module: rr_pick.
  - Combinational rotate-priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, winner index, any-valid flag.
  - Reused by future arbiters.
- FSM, pointer and hold counter stay in rr_arbiter.

Test Plan (N_REQ=3, HOLD_MAX=4 unless noted):
- Reset: hold i_rst_n=0, toggle i_req=3'b111 -> o_gnt=0, o_gnt_id=0, o_busy=0 throughout. Release reset with i_req=3'b111 -> o_gnt=3'b001 one edge later.
- Rotation: i_req=3'b111 constant, each owner drops i_req for 1 cycle after 2 grant cycles then reasserts -> grant order 001, 010, 100, 001, each separated by 1 RELEASE + 1 IDLE cycle.
- Skip and wrap: pointer=2 (after owner 1 released), i_req=3'b011 -> o_gnt=3'b001, o_gnt_id=0; pointer becomes 1 after release.
- Owner exclusivity: owner 0 granted; assert i_req[2] mid-grant -> o_gnt stays 3'b001 until i_req[0]=0; then RELEASE, then o_gnt=3'b100.
- Timeout (ARB_TIMEOUT_EN defined): i_req=3'b001 held forever -> o_gnt=001 for 4 cycles, then o_timeout=1 for 1 cycle with o_gnt=0, then re-grant 001. Without the macro -> o_gnt=001 indefinitely, o_timeout=0.
- Async reset mid-grant: o_gnt=3'b010, pulse i_rst_n low between clock edges -> o_gnt=0 immediately (before next edge); pointer=0 after reset.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: grant FSM state codes, default sizing and the
// pointer wrap helper.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANT   = 2'b01,
    ARB_RELEASE = 2'b10
  } arb_state_t;

  localparam int ARB_N_REQ_DEF    = 3;
  localparam int ARB_HOLD_MAX_DEF = 8;

  // Next index after id in a ring of n entries (n need not be a power of 2).
  function automatic int wrap_inc(input int id, input int n);
    return (id >= n - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or above ptr,
// wrapping from N-1 back to 0. Shared by arbiters in this family.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = ARB_N_REQ_DEF,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  logic [N-1:0] rot;
  int           off;
  int           sum;

  always_comb begin
    // rot[k] is the request at ring position ptr+k
    rot   = N'({req, req} >> ptr);
    valid = 1'b0;
    off   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    id  = valid ? ID_W'(sum) : '0;
    gnt = valid ? ({{(N-1){1'b0}}, 1'b1} << id) : '0;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with IDLE/GRANT/RELEASE grant FSM and registered grant.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = ARB_N_REQ_DEF,
  parameter int HOLD_MAX = ARB_HOLD_MAX_DEF,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_id,
  output logic             o_busy,
  output logic             o_timeout,
  output logic [1:0]       o_state
);

  if (N_REQ < 2) begin : g_bad_n_req
    $error("rr_arbiter: N_REQ must be >= 2");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("rr_arbiter: HOLD_MAX must be >= 1");
  end

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;
  logic             owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .id    (pick_id),
    .valid (pick_valid)
  );

  // Owner still wants the resource (gnt_q is one-hot during GRANT)
  assign owner_req = |(i_req & gnt_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_GRANT;
          gnt_d   = pick_gnt;
          id_d    = pick_id;
          owner_d = pick_id;
`ifdef ARB_TIMEOUT_EN
          cnt_d = CNT_W'(1);
`endif
        end
      end
      ARB_GRANT: begin
        if (!owner_req) begin
          state_d = ARB_RELEASE;
          gnt_d   = '0;
          id_d    = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q >= CNT_W'(HOLD_MAX)) begin
          state_d   = ARB_RELEASE;
          gnt_d     = '0;
          id_d      = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        id_d    = '0;
        ptr_d   = ID_W'(wrap_inc(int'(owner_q), N_REQ));
`ifdef ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      default: begin
        // Unused code 2'b11: recover to IDLE with the grant dropped
        state_d = ARB_IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_gnt    = gnt_q;
  assign o_gnt_id = id_q;
  assign o_busy   = (state_q == ARB_GRANT);
  assign o_state  = state_q;
`ifdef ARB_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N_REQ=3, HOLD_MAX=4): expected outputs are
// queued as each request pattern is driven and compared after the edge.
module tb_rr_arbiter;

  localparam int N_REQ    = 3;
  localparam int HOLD_MAX = 4;
  localparam int ID_W     = 2;
  localparam int EW       = N_REQ + ID_W + 2;

  logic             i_clk;
  logic             i_rst_n;
  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] o_gnt;
  logic [ID_W-1:0]  o_gnt_id;
  logic             o_busy;
  logic             o_timeout;
  logic [1:0]       o_state;

  logic [EW-1:0] exp_q[$];
  int checks;
  int failures;

  rr_arbiter #(.N_REQ(N_REQ), .HOLD_MAX(HOLD_MAX), .ID_W(ID_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req),
    .o_gnt     (o_gnt),
    .o_gnt_id  (o_gnt_id),
    .o_busy    (o_busy),
    .o_timeout (o_timeout),
    .o_state   (o_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_out(input logic [N_REQ-1:0] g, input logic [ID_W-1:0] id,
                                             input logic busy, input logic to);
    return {g, id, busy, to};
  endfunction

  // Called at a negedge: drive req, queue what must appear after the next
  // rising edge, then compare at the following negedge.
  task automatic step(input string tag, input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] g,
                      input logic [ID_W-1:0] id, input logic busy, input logic to);
    i_req = req;
    exp_q.push_back(pack_out(g, id, busy, to));
    @(posedge i_clk);
    @(negedge i_clk);
    pop_check(tag);
  endtask

  task automatic pop_check(input string tag);
    logic [EW-1:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 32'(pack_out(o_gnt, o_gnt_id, o_busy, o_timeout)), 32'(exp));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_rst_n  = 1'b0;
    i_req    = '0;
    @(negedge i_clk);

    // reset holds everything low whatever the requests do
    check("rst_state", 32'(o_state), 32'd0);
    step("rst_hold0", 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
    step("rst_hold1", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step("rst_hold2", 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    step("rst_rel", 3'b111, 3'b001, 2'd0, 1'b1, 1'b0);

    // rotation under full contention
    step("rot0_hold", 3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
    step("rot0_rel",  3'b110, 3'b000, 2'd0, 1'b0, 1'b0);
    step("rot0_idle", 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
    step("rot1_gnt",  3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
    step("rot1_hold", 3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
    step("rot1_rel",  3'b101, 3'b000, 2'd0, 1'b0, 1'b0);
    step("rot1_idle", 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
    step("rot2_gnt",  3'b111, 3'b100, 2'd2, 1'b1, 1'b0);
    step("rot2_hold", 3'b111, 3'b100, 2'd2, 1'b1, 1'b0);
    step("rot2_rel",  3'b011, 3'b000, 2'd0, 1'b0, 1'b0);
    step("rot2_idle", 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
    step("rot3_gnt",  3'b111, 3'b001, 2'd0, 1'b1, 1'b0);

    // skip and wrap: pointer 2 with requests 011 picks 0
    step("sw_rel0",   3'b010, 3'b000, 2'd0, 1'b0, 1'b0);
    step("sw_idle0",  3'b010, 3'b000, 2'd0, 1'b0, 1'b0);
    step("sw_gnt1",   3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
    step("sw_rel1",   3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step("sw_idle1",  3'b011, 3'b000, 2'd0, 1'b0, 1'b0);
    step("sw_wrap",   3'b011, 3'b001, 2'd0, 1'b1, 1'b0);
    step("sw_rel2",   3'b010, 3'b000, 2'd0, 1'b0, 1'b0);
    step("sw_idle2",  3'b011, 3'b000, 2'd0, 1'b0, 1'b0);
    step("sw_ptr1",   3'b011, 3'b010, 2'd1, 1'b1, 1'b0);

    // owner exclusivity
    step("ex_rel",    3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step("ex_idle",   3'b001, 3'b000, 2'd0, 1'b0, 1'b0);
    step("ex_gnt0",   3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
    step("ex_keep0",  3'b101, 3'b001, 2'd0, 1'b1, 1'b0);
    step("ex_keep1",  3'b101, 3'b001, 2'd0, 1'b1, 1'b0);
    step("ex_rel0",   3'b100, 3'b000, 2'd0, 1'b0, 1'b0);
    check("ex_state_rel", 32'(o_state), 32'd2);
    step("ex_idle2",  3'b100, 3'b000, 2'd0, 1'b0, 1'b0);
    step("ex_gnt2",   3'b100, 3'b100, 2'd2, 1'b1, 1'b0);
    step("ex_rel2",   3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step("ex_idle3",  3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

    // a request pulse that falls before the edge is never sampled
    i_req = 3'b001;
    #2;
    step("glitch", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

    // persistent single requester, pointer is 0 here
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < HOLD_MAX; i++)
      step("to_hold", 3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
    step("to_pulse",  3'b001, 3'b000, 2'd0, 1'b0, 1'b1);
    step("to_idle",   3'b001, 3'b000, 2'd0, 1'b0, 1'b0);
    step("to_regnt",  3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i < HOLD_MAX; i++)
      step("to_hold2", 3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 2 * HOLD_MAX; i++)
      step("nto_hold", 3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
`endif
    // owner drops exactly at the limit: ordinary release, no pulse
    step("lim_rel",   3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step("lim_idle",  3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

    // async reset mid-grant, pointer is 1 here
    step("ar_gnt1",   3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
    step("ar_hold1",  3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("ar_gnt_now",  32'(o_gnt),    32'd0);
    check("ar_id_now",   32'(o_gnt_id), 32'd0);
    check("ar_busy_now", 32'(o_busy),   32'd0);
    i_req = 3'b011;
    @(negedge i_clk);
    check("ar_gnt_held", 32'(o_gnt), 32'd0);
    i_rst_n = 1'b1;
    step("ar_ptr0",   3'b011, 3'b001, 2'd0, 1'b1, 1'b0);

    check("q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
